data_cache: RTL and testbench
=============================

DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 SHALL have parameter N_LINES, default 16, number of direct-mapped lines, power of 2, range 2..64.
REQ-002 SHALL have input CLK, 1 bit, clock; all state updates on its rising edge.
REQ-003 SHALL have input RESET, 1 bit, reset, asynchronous, active-low.
REQ-004 SHALL have inputs cpu_req (1), cpu_we (1), cpu_addr (32), cpu_wdata (32): the CPU load/store request, held stable while cpu_stall=1.
REQ-005 SHALL have outputs cpu_rdata (32), cpu_hit (1), cpu_stall (1): load data, same-cycle hit indication, CPU freeze.
REQ-006 SHALL have input flush, 1 bit, which invalidates all lines.
REQ-007 SHALL have outputs mem_req (1), mem_we (1), mem_addr (32), mem_wdata (32) toward the data memory.
REQ-008 SHALL have inputs mem_rdata (32) and mem_ready (1); mem_ready is a single-cycle completion pulse.

Function
REQ-009 SHALL index lines with cpu_addr[2+log2(N_LINES)-1:2]; tag = cpu_addr[31:2+log2(N_LINES)]; one 32-bit word per line; cpu_addr[1:0] ignored.
REQ-010 SHALL use FSM states IDLE, RD_MISS, WR_THRU; reset state IDLE.
REQ-011 In IDLE, read with valid and tag match: cpu_hit=1, cpu_rdata=line data combinationally, cpu_stall=0, zero added latency.
REQ-012 In IDLE, read miss: cpu_stall=1 combinationally, cpu_hit=0, go to RD_MISS next edge.
REQ-013 In RD_MISS: mem_req=1, mem_we=0, mem_addr={cpu_addr[31:2],2'b00}, cpu_stall=1 until mem_ready.
REQ-014 In the mem_ready cycle of RD_MISS: cpu_rdata=mem_rdata, cpu_stall=0, cpu_hit=0; line written with data, tag, valid=1 at that edge; return to IDLE.
REQ-015 Writes SHALL be write-through, no-write-allocate: IDLE with cpu_req and cpu_we -> cpu_stall=1, go to WR_THRU.
REQ-016 In WR_THRU: mem_req=1, mem_we=1, mem_addr word-aligned cpu_addr, mem_wdata=cpu_wdata; on mem_ready cpu_stall=0, return IDLE.
REQ-017 A write that hits SHALL update the line data at the mem_ready edge; a write miss SHALL leave the line array unchanged.
REQ-018 mem_req, mem_we SHALL be 0 in IDLE; cpu_stall=0 in IDLE when cpu_req=0.
REQ-019 flush SHALL clear all valid bits at the next edge in any state; if coincident with a RD_MISS mem_ready, the fill wins for that one line (valid=1).
REQ-020 mem_ready while in IDLE SHALL be ignored.
REQ-021 Back-to-back requests: a new request SHALL be evaluated in IDLE on the cycle after completion; no request is dropped or duplicated.
REQ-022 Hit/miss of a request SHALL be decided on the tag state at the cycle it is first seen in IDLE.

Reset
REQ-023 RESET low SHALL immediately force state IDLE, all valid bits 0, mem_req=0, mem_we=0, cpu_stall=0, cpu_hit=0.
REQ-024 Line data and tag storage need not be reset.
REQ-025 RESET asserted mid-miss SHALL abandon the transaction; a late mem_ready after release is ignored per REQ-020.

Configuration
REQ-026 Macro DCACHE_STATS_EN, when defined, SHALL add outputs hit_count (16) and miss_count (16), reset to 0.
REQ-027 With DCACHE_STATS_EN: hit_count +1 on each REQ-011 read hit, miss_count +1 on each IDLE->RD_MISS; both saturate at 16'hFFFF; writes not counted; flush does not clear them.
REQ-028 Without DCACHE_STATS_EN the ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-029 Cold read 0x810, mem_ready after 5 cycles, mem_rdata=0x12345678 -> cpu_stall high 5 cycles, cpu_rdata=0x12345678 in ready cycle; re-read 0x810 -> cpu_hit=1 same cycle, no mem_req.
REQ-030 Read 0x810 then 0x850 (N_LINES=16, same index, tag differs) -> second is miss; then 0x810 misses again.
REQ-031 Write 0x810=0xDEADBEEF after fill -> mem_we=1, mem_wdata=0xDEADBEEF; subsequent read 0x810 hits returning 0xDEADBEEF; write to uncached 0x820 -> later read 0x820 misses.
REQ-032 Fill 0x810, pulse flush -> read 0x810 misses; flush coincident with fill mem_ready -> that line valid, others invalid.
REQ-033 RESET low during RD_MISS -> cpu_stall, mem_req drop immediately; stray mem_ready after release ignored; next read misses.
REQ-034 With DCACHE_STATS_EN: 3 misses, 4 hits, 2 writes -> miss_count=3, hit_count=4.

Source files
------------

// File: rtl/data_cache.sv
// rtl/data_cache.sv - direct-mapped write-through, no-write-allocate data cache, one word per line
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module data_cache #(
  parameter int N_LINES = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_hit,
  output logic        cpu_stall,
  input  logic        flush,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`endif
);

  localparam int IW = $clog2(N_LINES);
  localparam int TW = 30 - IW;

  typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU} state_e;

  state_e             state_q;
  logic [N_LINES-1:0] valid_q;
  logic [TW-1:0]      tag_q  [N_LINES];
  logic [31:0]        data_q [N_LINES];
  logic               wr_hit_q;
  logic               mem_req_q;
  logic               mem_we_q;

  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic          lookup_hit;
  logic          rd_hit;
  logic          rd_miss;
  logic          unused_addr_bits;

  assign idx              = cpu_addr[IW+1:2];
  assign tag              = cpu_addr[31:IW+2];
  assign lookup_hit       = valid_q[idx] && (tag_q[idx] == tag);
  assign rd_hit           = RESET && (state_q == IDLE) && cpu_req && !cpu_we && lookup_hit;
  assign rd_miss          = (state_q == IDLE) && cpu_req && !cpu_we && !lookup_hit;
  assign unused_addr_bits = ^cpu_addr[1:0];

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = {cpu_addr[31:2], 2'b00};
  assign mem_wdata = cpu_wdata;

  always_comb begin
    cpu_hit   = 1'b0;
    cpu_stall = 1'b0;
    cpu_rdata = data_q[idx];
    case (state_q)
      IDLE: begin
        cpu_hit   = rd_hit;
        cpu_stall = cpu_req && (cpu_we || !lookup_hit);
      end
      RD_MISS: begin
        cpu_stall = !mem_ready;
        cpu_rdata = mem_rdata;
      end
      WR_THRU: cpu_stall = !mem_ready;
      default: cpu_stall = 1'b0;
    endcase
    // Reset must drop the CPU freeze immediately, even with a request pending.
    if (!RESET) begin
      cpu_stall = 1'b0;
      cpu_hit   = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= IDLE;
      valid_q   <= '0;
      wr_hit_q  <= 1'b0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
    end else begin
      if (flush) valid_q <= '0;
      case (state_q)
        IDLE: begin
          if (cpu_req && cpu_we) begin
            state_q   <= WR_THRU;
            wr_hit_q  <= lookup_hit;
            mem_req_q <= 1'b1;
            mem_we_q  <= 1'b1;
          end else if (rd_miss) begin
            state_q   <= RD_MISS;
            mem_req_q <= 1'b1;
          end
        end
        RD_MISS: begin
          if (mem_ready) begin
            // Placed after the flush clear so the filled line survives a coincident flush.
            valid_q[idx] <= 1'b1;
            state_q      <= IDLE;
            mem_req_q    <= 1'b0;
          end
        end
        WR_THRU: begin
          if (mem_ready) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (state_q == RD_MISS && mem_ready) begin
      tag_q[idx]  <= tag;
      data_q[idx] <= mem_rdata;
    end else if (state_q == WR_THRU && mem_ready && wr_hit_q) begin
      data_q[idx] <= cpu_wdata;
    end
  end

`ifdef DCACHE_STATS_EN
  logic [15:0] hit_cnt_q;
  logic [15:0] miss_cnt_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (rd_hit && hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
      if (rd_miss && miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_data_cache.sv
// tb/tb_data_cache.sv - directed and randomized checks of data_cache against an array-based cache model
module tb_data_cache;
  localparam int N = 16;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, flush = 1'b0, mem_ready = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, mem_rdata = '0;
  logic [31:0] cpu_rdata, mem_addr, mem_wdata;
  logic        cpu_hit, cpu_stall, mem_req, mem_we;
`ifdef DCACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  data_cache #(.N_LINES(N)) dut (
    .CLK(CLK), .RESET(RESET),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_hit(cpu_hit), .cpu_stall(cpu_stall), .flush(flush),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
`ifdef DCACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  // Reference model: line state per index, backing memory by word address, event counts.
  bit          mv [N];
  int unsigned mt [N];
  logic [31:0] md [N];
  logic [31:0] mem [int unsigned];
  int          m_hits = 0;
  int          m_miss = 0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic model_flush();
    for (int i = 0; i < N; i++) mv[i] = 1'b0;
  endtask

  // Entered at posedge+1; leaves at posedge+1 with the request dropped so the next call is back-to-back.
  task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input int delay, input bit fl, input string name);
    int unsigned li = (addr / 4) % N;
    int unsigned t  = addr / (4 * N);
    bit          hit = mv[li] && (mt[li] == t);
    int unsigned wa = addr & ~32'h3;
    int          stalls = 0;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    #4;
    chk({name, " hit"}, {31'b0, cpu_hit}, {31'b0, !we && hit});
    chk({name, " stall0"}, {31'b0, cpu_stall}, {31'b0, we || !hit});
    chk({name, " idle_mem_req"}, {31'b0, mem_req}, 32'd0);
    if (!we && hit) begin
      chk({name, " hit_data"}, cpu_rdata, md[li]);
      m_hits++;
    end else begin
      if (!we) m_miss++;
      if (!mem.exists(wa)) mem[wa] = $urandom;
      if (cpu_stall) stalls++;
      for (int k = 1; k <= delay; k++) begin
        @(posedge CLK); #1;
        mem_rdata = $urandom;
        if (k == delay) begin
          mem_ready = 1'b1;
          flush = fl;
          if (!we) mem_rdata = mem[wa];
        end
        #4;
        chk({name, " mem_req"}, {31'b0, mem_req}, 32'd1);
        chk({name, " mem_we"}, {31'b0, mem_we}, {31'b0, we});
        chk({name, " mem_addr"}, mem_addr, wa);
        if (we) chk({name, " mem_wdata"}, mem_wdata, wdata);
        chk({name, " stall"}, {31'b0, cpu_stall}, {31'b0, k != delay});
        if (cpu_stall) stalls++;
        if (k == delay && !we) begin
          chk({name, " fill_data"}, cpu_rdata, mem[wa]);
          chk({name, " fill_hit"}, {31'b0, cpu_hit}, 32'd0);
        end
      end
      chk({name, " stall_cycles"}, stalls, delay);
      if (fl) model_flush();
      if (we) begin
        mem[wa] = wdata;
        if (hit) md[li] = wdata;
      end else begin
        mv[li] = 1'b1; mt[li] = t; md[li] = mem[wa];
      end
    end
    @(posedge CLK); #1;
    mem_ready = 1'b0; flush = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    #4;
    chk("flush idle_stall", {31'b0, cpu_stall}, 32'd0);
    chk("flush idle_mem_req", {31'b0, mem_req}, 32'd0);
    @(posedge CLK); #1;
    flush = 1'b0;
    model_flush();
  endtask

  initial begin
    model_flush();
    #2;
    chk("reset stall", {31'b0, cpu_stall}, 32'd0);
    chk("reset hit", {31'b0, cpu_hit}, 32'd0);
    chk("reset mem_req", {31'b0, mem_req}, 32'd0);
    chk("reset mem_we", {31'b0, mem_we}, 32'd0);
    @(posedge CLK); #1;
    RESET = 1'b1;

    // Cold fill with a 5-cycle memory, then a same-cycle hit.
    mem[32'h810] = 32'h12345678;
    access(0, 32'h810, 0, 5, 0, "cold_rd");
    access(0, 32'h810, 0, 1, 0, "rehit");
    chk("rehit value", md[4], 32'h12345678);
    // Conflicting tag on the same index evicts.
    access(0, 32'h850, 0, 2, 0, "conflict");
    access(0, 32'h810, 0, 3, 0, "refetch");
    // Write-through hit updates the line; write miss does not allocate.
    access(1, 32'h810, 32'hDEADBEEF, 2, 0, "wr_hit");
    access(0, 32'h810, 0, 1, 0, "rd_after_wr");
    access(1, 32'h822, 32'hCAFEF00D, 3, 0, "wr_miss");
    access(0, 32'h820, 0, 2, 0, "rd_after_wr_miss");
    // Flush alone, then flush coincident with a fill.
    pulse_flush();
    access(0, 32'h810, 0, 1, 0, "post_flush");
    access(0, 32'h818, 0, 2, 0, "fill_818");
    access(0, 32'h824, 0, 2, 1, "fill_with_flush");
    access(0, 32'h824, 0, 1, 0, "kept_line");
    access(0, 32'h818, 0, 1, 0, "flushed_line");

`ifdef DCACHE_STATS_EN
    chk("hit_count", {16'b0, hit_count}, m_hits);
    chk("miss_count", {16'b0, miss_count}, m_miss);
`endif

    // Reset in the middle of a miss, then a stray completion pulse.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h900;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    chk("pre_reset mem_req", {31'b0, mem_req}, 32'd1);
    RESET = 1'b0;
    #1;
    chk("mid_reset stall", {31'b0, cpu_stall}, 32'd0);
    chk("mid_reset mem_req", {31'b0, mem_req}, 32'd0);
    chk("mid_reset hit", {31'b0, cpu_hit}, 32'd0);
    @(posedge CLK); #1;
    cpu_req = 1'b0; RESET = 1'b1; mem_ready = 1'b1; mem_rdata = 32'hBAD0BAD0;
    #3;
    chk("stray_ready mem_req", {31'b0, mem_req}, 32'd0);
    chk("stray_ready stall", {31'b0, cpu_stall}, 32'd0);
    @(posedge CLK); #1;
    mem_ready = 1'b0;
    #3;
    chk("after_stray mem_req", {31'b0, mem_req}, 32'd0);
    @(posedge CLK); #1;
    model_flush(); m_hits = 0; m_miss = 0;
    access(0, 32'h810, 0, 2, 0, "post_reset");

    // Randomized back-to-back traffic over three tags per index.
    for (int i = 0; i < 200; i++) begin
      logic [31:0] a = 32'h1000 + ($urandom_range(0, 47) << 2) + $urandom_range(0, 3);
      if ($urandom_range(0, 19) == 0) pulse_flush();
      access($urandom_range(0, 2) == 0, a, $urandom, $urandom_range(1, 4),
             $urandom_range(0, 9) == 0, "rand");
    end

`ifdef DCACHE_STATS_EN
    chk("final hit_count", {16'b0, hit_count}, m_hits);
    chk("final miss_count", {16'b0, miss_count}, m_miss);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
